// File: rtl/fpadd_arbiter_pkg.sv
// Shared constants for the fpadd arbiter and the fpadd unit it fronts:
// default datapath width/latency and the exception-flag encodings.
package fpadd_arbiter_pkg;

    localparam int DWIDTH_DEF = 32;
    localparam int LAT_DEF    = 5;
    localparam int FEX_W      = 3;

    localparam logic [FEX_W-1:0] FEX_OK   = 3'b000;
    localparam logic [FEX_W-1:0] FEX_INV  = 3'b001;
    localparam logic [FEX_W-1:0] FEX_UNF  = 3'b010;
    localparam logic [FEX_W-1:0] FEX_OVF  = 3'b100;
    localparam logic [FEX_W-1:0] FEX_LOST = 3'b111;

endpackage

// File: rtl/fpadd_result_fifo.sv
// Synchronous first-word-fall-through FIFO holding completed fpadd results.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, empty.
module fpadd_result_fifo
    import fpadd_arbiter_pkg::*;
#(
    parameter int WIDTH = DWIDTH_DEF + FEX_W + 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer separates full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;

    assign empty  = (wr_ptr == rd_ptr);
    assign do_pop = pop & ~empty;
    assign dout   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fpadd_arbiter.sv
// Round-robin front end sharing one pipelined fpadd among NREQ requesters.
// Ports: req_valid/ready/a/b per requester, resp_* valid/ready result port,
// fp_* to/from the adder, busy (work outstanding), err_tag (sticky).
module fpadd_arbiter
    import fpadd_arbiter_pkg::*;
#(
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int LAT        = LAT_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DWIDTH-1:0] req_a,
    input  logic [NREQ*DWIDTH-1:0] req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DWIDTH-1:0]      resp_sum,
    output logic [FEX_W-1:0]       resp_fex,
    output logic [IDW-1:0]         resp_id,
    output logic                   fp_valid,
    output logic [DWIDTH-1:0]      fp_a,
    output logic [DWIDTH-1:0]      fp_b,
    input  logic [DWIDTH-1:0]      fp_sum,
    input  logic [FEX_W-1:0]       fp_fex,
    input  logic                   fp_done,
    output logic                   busy,
    output logic                   err_tag
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = $clog2(LAT + 2);
    localparam int EW = DWIDTH + FEX_W + IDW;

    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    winner;
    logic [IDW-1:0]    fp_id;
    logic [NREQ-1:0]   grant;
    logic              found;
    logic              can_issue;
    logic              hs;
    logic              pop;
    logic [DWIDTH-1:0] win_a;
    logic [DWIDTH-1:0] win_b;
    logic [CW-1:0]     credits;
    logic [GW-1:0]     guard;
    logic [LAT-1:0]    tag_v;
    logic [IDW-1:0]    tag_id [LAT];
    logic              exit_v;
    logic [IDW-1:0]    exit_id;
    logic [EW-1:0]     push_data;
    logic [EW-1:0]     head;
    logic              empty;

    // Scan upward from rr_ptr with wrap; first valid requester wins.
    always_comb begin
        grant  = '0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                found  = 1'b1;
                winner = IDW'((int'(rr_ptr) + k) % NREQ);
                grant[(int'(rr_ptr) + k) % NREQ] = 1'b1;
            end
        end
    end

    assign win_a = req_a[int'(winner)*DWIDTH +: DWIDTH];
    assign win_b = req_b[int'(winner)*DWIDTH +: DWIDTH];

    // A credit is held from issue until the result leaves the FIFO,
    // so a push can never find the FIFO full.
    assign can_issue = (credits < CW'(FIFO_DEPTH)) && (guard == '0);
    assign req_ready = grant & {NREQ{can_issue}};
    assign hs        = found & can_issue;

    assign exit_v  = tag_v[LAT-1];
    assign exit_id = tag_id[LAT-1];

    // A tag without fp_done still yields an entry so the credit returns.
    assign push_data = fp_done ? {fp_sum, fp_fex, exit_id}
                               : {{DWIDTH{1'b0}}, FEX_LOST, exit_id};

    assign resp_valid = ~empty;
    assign pop        = resp_valid & resp_ready;
    assign {resp_sum, resp_fex, resp_id} = head;
    assign busy       = (credits != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            fp_valid <= 1'b0;
            fp_a     <= '0;
            fp_b     <= '0;
            fp_id    <= '0;
            rr_ptr   <= '0;
            credits  <= '0;
            guard    <= GW'(LAT + 1);
            tag_v    <= '0;
            err_tag  <= 1'b0;
        end else begin
            fp_valid <= hs;
            if (hs) begin
                fp_a   <= win_a;
                fp_b   <= win_b;
                fp_id  <= winner;
                rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
            end

            // Covers adder ops that were in flight when rst hit.
            if (guard != '0)
                guard <= guard - 1'b1;

            tag_v[0]  <= fp_valid;
            tag_id[0] <= fp_id;
            for (int k = 1; k < LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end

            case ({hs, pop})
                2'b10:   credits <= credits + 1'b1;
                2'b01:   credits <= credits - 1'b1;
                default: ;
            endcase

            if (exit_v && !fp_done)
                err_tag <= 1'b1;
            if (!exit_v && fp_done && guard == '0)
                err_tag <= 1'b1;
        end
    end

    fpadd_result_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (exit_v),
        .din   (push_data),
        .pop   (pop),
        .dout  (head),
        .empty (empty)
    );

endmodule
